// File: rtl/cl_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cl_ctrl_pkg
// Description : Shared types and constants for the Camera Link capture block.
// Revision    : 1.0 - initial release
// ============================================================================
package cl_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SYNC   = 3'd1,
        ST_WAIT   = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_DROP   = 3'd4
    } cap_state_t;

    localparam logic c_mode_continuous = 1'b0;
    localparam logic c_mode_single     = 1'b1;

    // Fill bit replicated to counter width to form the saturation value.
    localparam logic c_sat_fill = 1'b1;

endpackage
`default_nettype wire

// File: rtl/cl_eol_stage.sv
`default_nettype none
// ============================================================================
// Module      : cl_eol_stage
// Description : Hold + output register pair giving one-pixel lookahead so the
//               last pixel of a line can be tagged with tlast.
// Revision    : 1.0 - initial release
// ============================================================================
module cl_eol_stage
    import cl_ctrl_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              capture,
    input  logic              in_line,
    input  logic              pix_accept,
    input  logic [DATA_W-1:0] pix_data,
    input  logic              sof_arm,
    input  logic              m_tready,
    output logic [DATA_W-1:0] m_tdata,
    output logic              m_tvalid,
    output logic              m_tuser,
    output logic              m_tlast,
    output logic              overflow
);

    logic [DATA_W-1:0] r_h_data;
    logic              r_h_valid;
    logic [DATA_W-1:0] r_o_data;
    logic              r_o_valid;
    logic              r_o_user;
    logic              r_o_last;
    logic              r_sof_pending;

    logic w_eol;
    logic w_need_load;
    logic w_o_free;
    logic w_load;

    assign w_eol       = capture & r_h_valid & ~in_line;
    assign w_need_load = (pix_accept & r_h_valid) | w_eol;
    assign w_o_free    = ~r_o_valid | m_tready;
    assign w_load      = w_need_load & w_o_free;
    assign overflow    = w_need_load & ~w_o_free;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_h_data      <= '0;
            r_h_valid     <= 1'b0;
            r_o_data      <= '0;
            r_o_valid     <= 1'b0;
            r_o_user      <= 1'b0;
            r_o_last      <= 1'b0;
            r_sof_pending <= 1'b0;
        end else begin
            if (r_o_valid && m_tready) begin
                r_o_valid <= 1'b0;
            end
            if (w_load) begin
                r_o_data  <= r_h_data;
                r_o_last  <= w_eol;
                r_o_user  <= r_sof_pending;
                r_o_valid <= 1'b1;
            end
            if (sof_arm) begin
                r_sof_pending <= 1'b1;
            end else if (w_load) begin
                r_sof_pending <= 1'b0;
            end
            // A stalled load abandons the held pixel; the FSM drops the rest.
            if (overflow) begin
                r_h_valid <= 1'b0;
            end else if (pix_accept) begin
                r_h_valid <= 1'b1;
                r_h_data  <= pix_data;
            end else if (w_eol) begin
                r_h_valid <= 1'b0;
            end
        end
    end

    assign m_tdata  = r_o_data;
    assign m_tvalid = r_o_valid;
    assign m_tuser  = r_o_user;
    assign m_tlast  = r_o_last;

endmodule
`default_nettype wire

// File: rtl/cl_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cl_capture_ctrl
// Description : Camera Link frame capture sequencer with AXI4-Stream output
//               and frame geometry checking.
// Revision    : 1.0 - initial release
// ============================================================================
module cl_capture_ctrl
    import cl_ctrl_pkg::*;
#(
    parameter int VID_DATA_SIZE = 16,
    parameter int CNT_W         = 12
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cl_fval,
    input  logic                     cl_lval,
    input  logic                     cl_pix_valid,
    input  logic [VID_DATA_SIZE-1:0] cl_pix_data,
    input  logic                     cfg_enable,
    input  logic                     cfg_single,
    input  logic                     cfg_arm,
    input  logic [CNT_W-1:0]         cfg_width,
    input  logic [CNT_W-1:0]         cfg_height,
    input  logic                     err_clr,
    output logic [VID_DATA_SIZE-1:0] m_tdata,
    output logic                     m_tvalid,
    input  logic                     m_tready,
    output logic                     m_tuser,
    output logic                     m_tlast,
    output logic                     busy,
    output logic                     frame_done,
    output logic [15:0]              frame_cnt,
    output logic [CNT_W-1:0]         last_width,
    output logic [CNT_W-1:0]         last_height,
    output logic                     err_width,
    output logic                     err_height,
    output logic                     err_overflow
);

    localparam logic [CNT_W-1:0] c_cnt_sat = {CNT_W{c_sat_fill}};
    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

    cap_state_t       r_state;
    logic [CNT_W-1:0] r_pix_cnt;
    logic [CNT_W-1:0] r_line_cnt;
    logic             r_frame_done;
    logic [15:0]      r_frame_cnt;
    logic [CNT_W-1:0] r_last_width;
    logic [CNT_W-1:0] r_last_height;
    logic             r_err_width;
    logic             r_err_height;
    logic             r_err_overflow;

    logic             w_capture;
    logic             w_in_line;
    logic             w_accept;
    logic             w_line_end;
    logic             w_sof_arm;
    logic             w_rearm;
    logic             w_overflow;
    logic             w_frame_end;
    logic             w_width_bad;
    logic             w_height_bad;
    logic [CNT_W-1:0] w_pix_inc;
    logic [CNT_W-1:0] w_line_next;
    cap_state_t       w_exit_state;

    assign w_capture  = (r_state == ST_ACTIVE);
    assign w_in_line  = cl_fval & cl_lval;
    assign w_accept   = w_capture & w_in_line & cl_pix_valid;
    // Empty lines never reach the counter, so a nonzero count marks a real line.
    assign w_line_end = w_capture & ~w_in_line & (r_pix_cnt != '0);
    assign w_sof_arm  = (r_state == ST_WAIT) & cl_fval;
    assign w_rearm    = cfg_enable & (cfg_single != c_mode_single);

    assign w_pix_inc    = (r_pix_cnt == c_cnt_sat) ? r_pix_cnt : r_pix_cnt + c_cnt_one;
    assign w_line_next  = !w_line_end ? r_line_cnt :
                          (r_line_cnt == c_cnt_sat) ? r_line_cnt : r_line_cnt + c_cnt_one;
    assign w_frame_end  = w_capture & ~cl_fval & ~w_overflow;
    assign w_width_bad  = w_line_end & (r_pix_cnt != cfg_width);
    assign w_height_bad = w_frame_end & (w_line_next != cfg_height);
    assign w_exit_state = w_rearm ? ST_WAIT : ST_IDLE;

    cl_eol_stage #(
        .DATA_W (VID_DATA_SIZE)
    ) u_eol_stage (
        .clk        (clk),
        .rst        (rst),
        .capture    (w_capture),
        .in_line    (w_in_line),
        .pix_accept (w_accept),
        .pix_data   (cl_pix_data),
        .sof_arm    (w_sof_arm),
        .m_tready   (m_tready),
        .m_tdata    (m_tdata),
        .m_tvalid   (m_tvalid),
        .m_tuser    (m_tuser),
        .m_tlast    (m_tlast),
        .overflow   (w_overflow)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_pix_cnt      <= '0;
            r_line_cnt     <= '0;
            r_frame_done   <= 1'b0;
            r_frame_cnt    <= '0;
            r_last_width   <= '0;
            r_last_height  <= '0;
            r_err_width    <= 1'b0;
            r_err_height   <= 1'b0;
            r_err_overflow <= 1'b0;
        end else begin
            r_frame_done   <= 1'b0;
            r_err_width    <= (r_err_width & ~err_clr) | w_width_bad;
            r_err_height   <= (r_err_height & ~err_clr) | w_height_bad;
            r_err_overflow <= (r_err_overflow & ~err_clr) | w_overflow;
            case (r_state)
                ST_IDLE: begin
                    if (cfg_enable && ((cfg_single == c_mode_continuous) || cfg_arm)) begin
                        r_state <= ST_SYNC;
                    end
                end
                ST_SYNC: begin
                    if (!cl_fval) begin
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cl_fval) begin
                        r_state    <= ST_ACTIVE;
                        r_pix_cnt  <= '0;
                        r_line_cnt <= '0;
                    end
                end
                ST_ACTIVE: begin
                    if (w_accept) begin
                        r_pix_cnt <= w_pix_inc;
                    end
                    if (w_line_end) begin
                        r_last_width <= r_pix_cnt;
                        r_pix_cnt    <= '0;
                        r_line_cnt   <= w_line_next;
                    end
                    if (w_overflow) begin
                        r_state <= ST_DROP;
                    end else if (!cl_fval) begin
                        r_last_height <= w_line_next;
                        r_frame_done  <= 1'b1;
                        r_frame_cnt   <= r_frame_cnt + 16'd1;
                        r_state       <= w_exit_state;
                    end
                end
                ST_DROP: begin
                    if (!cl_fval) begin
                        r_state <= w_exit_state;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy         = (r_state != ST_IDLE);
    assign frame_done   = r_frame_done;
    assign frame_cnt    = r_frame_cnt;
    assign last_width   = r_last_width;
    assign last_height  = r_last_height;
    assign err_width    = r_err_width;
    assign err_height   = r_err_height;
    assign err_overflow = r_err_overflow;

endmodule
`default_nettype wire
